// File: rtl/gf256_log_engine_if.sv
// Request/result handshake bundle for the GF(2^8) discrete-log engine.
// slave = engine side, master = requester/consumer side.
interface gf256_log_engine_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_elem;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_exp;
  logic       out_zero;

  modport slave (
    input  in_valid, in_elem, out_ready,
    output in_ready, out_valid, out_exp, out_zero
  );

  modport master (
    output in_valid, in_elem, out_ready,
    input  in_ready, out_valid, out_exp, out_zero
  );
endinterface

// File: rtl/gf256_log_engine.sv
// Sequential GF(2^8) discrete log: walks alpha^count from alpha^0 until it equals the target.
// Optional macro GF256_LOG_DUAL_WALK_EN adds a second walker starting at alpha^127.
module gf256_log_engine #(
  parameter logic [7:0] POLY = 8'h1D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gf256_log_engine_if.slave     bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic logic [7:0] f_step(input logic [7:0] w);
    return {w[6:0], 1'b0} ^ (w[7] ? POLY : 8'h00);
  endfunction

  state_t     r_state;
  logic [7:0] r_target;
  logic [7:0] r_walk_a;
  logic [7:0] r_count;
  logic [7:0] r_exp;
  logic       r_zero;
  logic       r_out_valid;

  logic       w_hit_a;
  logic       w_hit_b;
  logic [7:0] w_exp_b;

`ifdef GF256_LOG_DUAL_WALK_EN
  function automatic logic [7:0] f_pow(input int n);
    logic [7:0] w;
    w = 8'h01;
    for (int i = 0; i < n; i++) begin
      w = f_step(w);
    end
    return w;
  endfunction

  localparam logic [7:0] B_START = f_pow(127);

  logic [7:0] r_walk_b;

  // Walker A owns exponents 0..126; B owns 127..254 and is always 127 steps ahead.
  assign w_hit_a = (r_walk_a == r_target) && (r_count <= 8'd126);
  assign w_hit_b = (r_walk_b == r_target);
  assign w_exp_b = r_count + 8'd127;
`else
  assign w_hit_a = (r_walk_a == r_target);
  assign w_hit_b = 1'b0;
  assign w_exp_b = 8'h00;
`endif

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.out_exp   = r_exp;
  assign bus.out_zero  = r_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_target    <= 8'h00;
      r_walk_a    <= 8'h01;
      r_count     <= 8'h00;
      r_exp       <= 8'h00;
      r_zero      <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef GF256_LOG_DUAL_WALK_EN
      r_walk_b    <= B_START;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_target <= bus.in_elem;
            if (bus.in_elem == 8'h00) begin
              r_state     <= ST_DONE;
              r_exp       <= 8'h00;
              r_zero      <= 1'b1;
              r_out_valid <= 1'b1;
            end else begin
              r_state  <= ST_SEARCH;
              r_walk_a <= 8'h01;
              r_count  <= 8'h00;
`ifdef GF256_LOG_DUAL_WALK_EN
              r_walk_b <= B_START;
`endif
            end
          end
        end

        ST_SEARCH: begin
          if (w_hit_a) begin
            r_state     <= ST_DONE;
            r_exp       <= r_count;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b1;
          end else if (w_hit_b) begin
            r_state     <= ST_DONE;
            r_exp       <= w_exp_b;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b1;
          end else if (r_count == 8'd254) begin
            // Cannot happen for a nonzero element; guarantees the search terminates.
            r_state     <= ST_DONE;
            r_exp       <= 8'h00;
            r_zero      <= 1'b1;
            r_out_valid <= 1'b1;
          end else begin
            r_walk_a <= f_step(r_walk_a);
            r_count  <= r_count + 8'd1;
`ifdef GF256_LOG_DUAL_WALK_EN
            r_walk_b <= f_step(r_walk_b);
`endif
          end
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf256_log_engine.sv
// Directed and sweep bench for gf256_log_engine: exponent values, latency, hold, reset.
module tb_gf256_log_engine;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  logic [7:0] pow_tbl [0:254];
  logic [7:0] log_tbl [0:255];

  gf256_log_engine_if bus ();

  gf256_log_engine #(.POLY(8'h1D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  function automatic int exp_lat(input int k);
`ifdef GF256_LOG_DUAL_WALK_EN
    return (k <= 126) ? k + 1 : k - 126;
`else
    return k + 1;
`endif
  endfunction

  // One request/response; lat = clock edges after the accept edge before out_valid is seen.
  task automatic do_req(input logic [7:0] e, input int hold,
                        output logic [7:0] x, output logic z, output int lat);
    int guard;
    x = 8'h00;
    z = 1'b0;
    lat = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_elem  = e;
    guard = 0;
    while (!bus.in_ready && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid) begin
      check("result_timeout", 32'd0, 32'd1);
      return;
    end
    repeat (hold) @(negedge clk);
    x = bus.out_exp;
    z = bus.out_zero;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    $display("req elem=0x%02h exp=%0d zero=%0d lat=%0d hold=%0d", e, x, z, lat, hold);
  endtask

  task automatic directed(input string tag, input logic [7:0] e, input int k_want,
                          input logic z_want, input int lat_want);
    logic [7:0] x;
    logic       z;
    int         lat;
    do_req(e, 0, x, z, lat);
    check({tag, "_exp"}, x, k_want);
    check({tag, "_zero"}, z, z_want);
    check({tag, "_lat"}, lat, lat_want);
  endtask

  initial begin
    logic [7:0] x;
    logic       z;
    int         lat;
    int         guard;

    n_cmp = 0;
    n_err = 0;
    pow_tbl[0] = 8'h01;
    for (int i = 1; i < 255; i++)
      pow_tbl[i] = {pow_tbl[i-1][6:0], 1'b0} ^ (pow_tbl[i-1][7] ? 8'h1D : 8'h00);
    for (int i = 0; i < 256; i++) log_tbl[i] = 8'h00;
    for (int i = 0; i < 255; i++) log_tbl[pow_tbl[i]] = i[7:0];

    bus.in_valid  = 1'b0;
    bus.in_elem   = 8'h00;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_exp", bus.out_exp, 0);
    check("rst_out_zero", bus.out_zero, 0);
    rst_n = 1'b1;

    directed("e01", 8'h01, 0, 1'b0, 1);
    directed("e8e", 8'h8E, 254, 1'b0, exp_lat(254));
    directed("ecc", 8'hCC, 127, 1'b0, exp_lat(127));
    directed("e00", 8'h00, 0, 1'b1, 0);
    directed("e02", 8'h02, 1, 1'b0, 2);

    // Result held under back-pressure while a competing request waits.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_elem  = 8'h1D;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("e1d_lat", guard, 9);
    bus.in_valid = 1'b1;
    bus.in_elem  = 8'h02;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 1);
      check("hold_exp", bus.out_exp, 8);
      check("hold_in_ready", bus.in_ready, 0);
    end
    $display("req elem=0x1d exp=%0d zero=%0d held 10 cycles", bus.out_exp, bus.out_zero);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("post_hs_valid", bus.out_valid, 0);
    check("post_hs_in_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check("queued_exp", bus.out_exp, 1);
    check("queued_lat", guard, 2);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    $display("req elem=0x02 exp=1 after competing wait");

    // Full sweep against the power-table inverse with random back-pressure and gaps.
    for (int e = 1; e < 256; e++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_req(e[7:0], $urandom_range(0, 4), x, z, lat);
      check("sweep_exp", x, log_tbl[e]);
      check("sweep_zero", z, 0);
      check("sweep_lat", lat, exp_lat(int'(log_tbl[e])));
    end

    // Reset during SEARCH.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_elem  = 8'h8E;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (49) @(negedge clk);
    check("search_in_ready", bus.in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_search_valid", bus.out_valid, 0);
    check("rst_search_in_ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    directed("after_rst", 8'h02, 1, 1'b0, 2);

    // Reset while a result is pending must drop out_valid without a clock edge.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_elem  = 8'h01;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("done_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_valid", bus.out_valid, 0);
    check("rst_done_exp", bus.out_exp, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    directed("after_rst2", 8'h1D, 8, 1'b0, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
